// File: rtl/gru_seq_driver.sv
// Time-steps a combinational gru_lstm cell: holds X and the hidden state on the cell
// inputs for SETTLE cycles, captures h_out as the new hidden state and streams it out.
module gru_seq_driver #(
    parameter int          W       = 8,
    parameter int          SEQ_LEN = 4,
    parameter int          SETTLE  = 2,
    parameter logic [W-1:0] H_INIT = {W{1'b0}},
    localparam int         SW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int         CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [W-1:0]  x_data,
    input  logic          seq_clear,
    output logic [W-1:0]  cell_x,
    output logic [W-1:0]  cell_h_in,
    input  logic [W-1:0]  cell_h_out,
    output logic          h_valid,
    input  logic          h_ready,
    output logic [W-1:0]  h_data,
    output logic          h_last,
    output logic [SW-1:0] step_idx,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   h_r;
    logic [W-1:0]   x_r;
    logic [CW-1:0]  cnt;
    logic           clear_pend;

    assign cell_x    = x_r;
    assign cell_h_in = h_r;

    // Step sequencer; x_ready and busy are registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            h_r        <= H_INIT;
            x_r        <= {W{1'b0}};
            cnt        <= {CW{1'b0}};
            step_idx   <= {SW{1'b0}};
            clear_pend <= 1'b0;
            h_valid    <= 1'b0;
            h_data     <= {W{1'b0}};
            h_last     <= 1'b0;
            x_ready    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A clear issued together with an accept still makes the new sample step 0.
                    if (seq_clear) begin
                        h_r      <= H_INIT;
                        step_idx <= {SW{1'b0}};
                    end
                    if (x_valid) begin
                        x_r     <= x_data;
                        cnt     <= {CW{1'b0}};
                        state   <= EVAL;
                        x_ready <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                EVAL: begin
                    if (seq_clear) begin
                        clear_pend <= 1'b1;
                    end
                    if (cnt == CW'(SETTLE - 1)) begin
                        h_r     <= cell_h_out;
                        h_data  <= cell_h_out;
                        h_last  <= (step_idx == SW'(SEQ_LEN - 1));
                        h_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (seq_clear) begin
                        clear_pend <= 1'b1;
                    end
                    if (h_valid && h_ready) begin
                        h_valid <= 1'b0;
                        state   <= IDLE;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                        // A clear arriving on the handshake cycle itself is honoured here too.
                        if (h_last || clear_pend || seq_clear) begin
                            h_r        <= H_INIT;
                            step_idx   <= {SW{1'b0}};
                            clear_pend <= 1'b0;
                        end else begin
                            step_idx <= step_idx + SW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    h_valid <= 1'b0;
                    x_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gru_seq_driver.sv
// Scoreboard bench for gru_seq_driver with a stub cell h_out = (h_in>>>1)+(X>>>1).
module tb_gru_seq_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic       x_ready;
    logic [7:0] x_data = 8'h00;
    logic       seq_clear = 1'b0;
    logic [7:0] cell_x;
    logic [7:0] cell_h_in;
    logic [7:0] cell_h_out;
    logic       h_valid;
    logic       h_ready = 1'b1;
    logic [7:0] h_data;
    logic       h_last;
    logic [1:0] step_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit hr_rand = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] step;
    } exp_t;
    exp_t sb[$];

    // Reference state: hidden value and position inside the sequence.
    logic signed [7:0] m_h = 8'sh00;
    int                m_step = 0;

    gru_seq_driver #(.W(8), .SEQ_LEN(4), .SETTLE(2), .H_INIT(8'h00)) dut (
        .clk(clk), .rst(rst),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .seq_clear(seq_clear),
        .cell_x(cell_x), .cell_h_in(cell_h_in), .cell_h_out(cell_h_out),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_last(h_last),
        .step_idx(step_idx), .busy(busy)
    );

    assign cell_h_out = 8'(($signed(cell_h_in) >>> 1) + ($signed(cell_x) >>> 1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model one step: optional clear before the sample, optional clear after it.
    task automatic model_push(input logic [7:0] x, input bit clr_before, input bit clr_after);
        logic signed [7:0] xs;
        exp_t e;
        bit last;
        if (clr_before) begin
            m_h = 8'sh00;
            m_step = 0;
        end
        xs = x;
        e.data = 8'((m_h >>> 1) + (xs >>> 1));
        last = (m_step == 3);
        e.last = last;
        e.step = 2'(m_step);
        sb.push_back(e);
        m_h = e.data;
        if (last || clr_after) begin
            m_h = 8'sh00;
            m_step = 0;
        end else begin
            m_step++;
        end
    endtask

    // Monitor: every handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && h_valid && h_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {24'h0, h_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("h_data", {24'h0, h_data}, {24'h0, e.data});
                chk("h_last", {31'h0, h_last}, {31'h0, e.last});
                chk("step_idx", {30'h0, step_idx}, {30'h0, e.step});
            end
        end
    end

    // Random backpressure generator, enabled only in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hr_rand) h_ready = 1'($urandom_range(0, 1));
        end
    end

    // mode: 0 plain, 1 clear together with the sample, 2 clear during EVAL.
    task automatic send(input logic [7:0] x, input int mode);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        x_valid = 1'b1;
        x_data = x;
        seq_clear = (mode == 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (x_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'h0, 32'h1);
            x_valid = 1'b0;
            seq_clear = 1'b0;
            return;
        end
        model_push(x, mode == 1, mode == 2);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        seq_clear = 1'b0;
        if (mode == 2) begin
            seq_clear = 1'b1;
            @(posedge clk);
            #1;
            seq_clear = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic [7:0] held;
        bit ok;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_x_ready", {31'h0, x_ready}, 32'h1);
        chk("rst_h_valid", {31'h0, h_valid}, 32'h0);
        chk("rst_cell_h_in", {24'h0, cell_h_in}, 32'h0);
        chk("rst_step_idx", {30'h0, step_idx}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cell_x", {24'h0, cell_x}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed sequence: expect 08,0C,FE,FF with last on the fourth.
        send(8'h10, 0);
        send(8'h10, 0);
        send(8'hF0, 0);
        send(8'h01, 0);
        drain();
        chk("seq_wrap_h_in", {24'h0, cell_h_in}, 32'h0);
        chk("seq_wrap_step", {30'h0, step_idx}, 32'h0);

        // Backpressure: result held for five cycles, nothing accepted meanwhile.
        h_ready = 1'b0;
        send(8'h10, 0);
        x_valid = 1'b1;
        x_data = 8'h55;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (h_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", {31'h0, ok}, 32'h1);
        held = h_data;
        chk("bp_data", {24'h0, h_data}, 32'h08);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", {24'h0, h_data}, {24'h0, held});
            chk("bp_hold_last", {31'h0, h_last}, 32'h0);
            chk("bp_x_ready", {31'h0, x_ready}, 32'h0);
        end
        x_valid = 1'b0;
        h_ready = 1'b1;
        drain();

        // Clear during EVAL of step 1: step 1 still reads 0C, next sample restarts.
        send(8'h10, 1);
        send(8'h10, 2);
        drain();
        chk("clr_h_in", {24'h0, cell_h_in}, 32'h0);
        chk("clr_step", {30'h0, step_idx}, 32'h0);
        send(8'h10, 0);
        drain();

        // Latency: accept at edge T, valid after T+2, cell_x stable meanwhile.
        @(posedge clk);
        #1;
        x_valid = 1'b1;
        x_data = 8'h22;
        @(negedge clk);
        chk("lat_ready", {31'h0, x_ready}, 32'h1);
        model_push(8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        @(negedge clk);
        chk("lat_t0_valid", {31'h0, h_valid}, 32'h0);
        chk("lat_t0_cell_x", {24'h0, cell_x}, 32'h22);
        @(negedge clk);
        chk("lat_t1_valid", {31'h0, h_valid}, 32'h0);
        chk("lat_t1_cell_x", {24'h0, cell_x}, 32'h22);
        @(negedge clk);
        chk("lat_t2_valid", {31'h0, h_valid}, 32'h1);
        drain();

        // Reset mid-EVAL drops the step and restores the initial hidden state.
        @(posedge clk);
        #1;
        x_valid = 1'b1;
        x_data = 8'h40;
        @(negedge clk);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        rst = 1'b1;
        m_h = 8'sh00;
        m_step = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (h_valid) seen = 1'b1;
        end
        chk("rst_abort_no_valid", {31'h0, seen}, 32'h0);
        send(8'h10, 0);
        drain();

        // Random phase with random backpressure and clears.
        hr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(8'($urandom), (r == 0) ? 1 : ((r == 1) ? 2 : 0));
        end
        hr_rand = 1'b0;
        @(posedge clk);
        #1;
        h_ready = 1'b1;
        drain();
        chk("final_sb_empty", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
